// File: rtl/maclaurin_stream_driver_if.sv
// Pipeline-side handshake between the stream driver (master) and the series pipeline (slave).
interface maclaurin_stream_driver_if #(
    parameter int OUTPUT_WIDTH = 32
);
    logic                           p_start;
    logic [2:0]                     p_N;
    logic signed [7:0]              p_X;
    logic                           p_rst;
    logic                           p_ready;
    logic                           p_valid;
    logic signed [OUTPUT_WIDTH-1:0] p_Y;
    logic                           p_overflow;
    logic                           p_error;

    modport master (
        output p_start, p_N, p_X, p_rst,
        input  p_ready, p_valid, p_Y, p_overflow, p_error
    );
    modport slave (
        input  p_start, p_N, p_X, p_rst,
        output p_ready, p_valid, p_Y, p_overflow, p_error
    );
endinterface

// File: rtl/maclaurin_stream_driver.sv
// Buffers signed samples, streams them into a Maclaurin series pipeline and collects its results.
// Define MACLAURIN_DRV_OVF_CNT_EN to add the ovf_count output.
module maclaurin_stream_driver #(
    parameter int DEPTH        = 32,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_wr,
    input  logic signed [7:0]          s_data,
    output logic                       s_full,
    output logic [$clog2(DEPTH):0]     s_count,
    input  logic                       go,
    input  logic [2:0]                 n_cfg,
    output logic                       busy,
    output logic                       done,
    maclaurin_stream_driver_if.master  pif,
    input  logic                       r_rd,
    output logic [OUTPUT_WIDTH:0]      r_data,
    output logic                       r_empty,
    output logic                       r_drop,
    output logic                       err_seen
`ifdef MACLAURIN_DRV_OVF_CNT_EN
    ,
    output logic [7:0]                 ovf_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = OUTPUT_WIDTH + 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, CFG, FEED, DRAIN, DONE} state_t;

    state_t      state;
    logic [2:0]  n_lat;
    logic [2:0]  p_n_r;
    logic        p_start_r, p_rst_r, busy_r, done_r;
    logic [3:0]  drain_cnt;
    logic [AW:0] sent, recv;

    logic signed [7:0] s_mem [DEPTH];
    logic [AW-1:0]     s_wp, s_rp;
    logic [AW:0]       s_cnt;
    logic              s_empty, s_push, s_pop;

    logic [RW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wp, r_rp;
    logic [AW:0]       r_cnt;
    logic              r_full, r_push, r_pop;

    logic accept, cap, drop;

    assign s_empty = (s_cnt == '0);
    assign s_push  = s_wr && (state == IDLE) && (s_cnt != CNT_FULL);
    assign s_pop   = (state == FEED) && pif.p_ready && !s_empty;
    assign accept  = (state == IDLE) && go && !s_empty;

    assign r_full  = (r_cnt == CNT_FULL);
    assign r_pop   = r_rd && (r_cnt != '0);
    assign cap     = busy_r && pif.p_valid && pif.p_ready;
    // A full FIFO still accepts a capture when a read frees the head on the same edge
    assign r_push  = cap && (!r_full || r_pop);
    assign drop    = cap && r_full && !r_rd;

    assign s_full      = busy_r || (s_cnt == CNT_FULL);
    assign s_count     = s_cnt;
    assign busy        = busy_r;
    assign done        = done_r;
    assign r_data      = r_mem[r_rp];
    assign r_empty     = (r_cnt == '0);
    assign pif.p_start = p_start_r;
    assign pif.p_rst   = p_rst_r;
    assign pif.p_N     = p_n_r;
    assign pif.p_X     = ((state == FEED) && !s_empty) ? s_mem[s_rp] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_wp  <= '0;
            s_rp  <= '0;
            s_cnt <= '0;
        end else begin
            if (s_push) s_wp <= s_wp + 1'b1;
            if (s_pop)  s_rp <= s_rp + 1'b1;
            if (s_push && !s_pop)      s_cnt <= s_cnt + 1'b1;
            else if (s_pop && !s_push) s_cnt <= s_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s_push) s_mem[s_wp] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (r_push) r_wp <= r_wp + 1'b1;
            if (r_pop)  r_rp <= r_rp + 1'b1;
            if (r_push && !r_pop)      r_cnt <= r_cnt + 1'b1;
            else if (r_pop && !r_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_push) r_mem[r_wp] <= {pif.p_overflow, pif.p_Y};
    end

    // Run bookkeeping; recv counts every capture, including ones dropped at a full FIFO
    always_ff @(posedge clk) begin
        if (!rst) begin
            sent     <= '0;
            recv     <= '0;
            r_drop   <= 1'b0;
            err_seen <= 1'b0;
        end else if (accept) begin
            sent     <= '0;
            recv     <= '0;
            r_drop   <= 1'b0;
            err_seen <= 1'b0;
        end else begin
            if (s_pop) sent <= sent + 1'b1;
            if (cap)   recv <= recv + 1'b1;
            if (drop)  r_drop <= 1'b1;
            if (busy_r && pif.p_error) err_seen <= 1'b1;
        end
    end

`ifdef MACLAURIN_DRV_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)                                           ovf_count <= '0;
        else if (accept)                                    ovf_count <= '0;
        else if (cap && pif.p_overflow && ovf_count != 8'hFF) ovf_count <= ovf_count + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            n_lat     <= '0;
            p_n_r     <= '0;
            p_start_r <= 1'b0;
            p_rst_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            drain_cnt <= '0;
        end else begin
            p_start_r <= 1'b0;
            p_rst_r   <= 1'b0;
            done_r    <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state     <= START;
                    n_lat     <= n_cfg;
                    busy_r    <= 1'b1;
                    p_start_r <= 1'b1;
                end
                START: begin
                    state <= CFG;
                    p_n_r <= n_lat;
                end
                CFG: state <= FEED;
                FEED: if (s_pop && s_cnt == 1) begin
                    state     <= DRAIN;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    if (recv == sent || drain_cnt == 4'd15) begin
                        state   <= DONE;
                        done_r  <= 1'b1;
                        p_rst_r <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    p_n_r  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/maclaurin_stream_driver.md
MACLAURIN_STREAM_DRIVER -- requirements
Module: maclaurin_stream_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 32, sample and result FIFO depth (power of 2, >= 4).
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 32, pipeline result width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports s_wr input 1 write sample; s_data input 8 signed sample; s_full output 1; s_count output log2(DEPTH)+1 samples held.
REQ-006 SHALL have ports go input 1 start run; n_cfg input 3 series order; busy output 1; done output 1 one-cycle pulse.
REQ-007 SHALL have pipeline-side ports p_start output 1; p_N output 3; p_X output 8 signed; p_rst output 1 active-high; p_ready input 1; p_valid input 1; p_Y input OUTPUT_WIDTH signed; p_overflow input 1; p_error input 1.
REQ-008 SHALL have result ports r_rd input 1; r_data output OUTPUT_WIDTH+1 = {overflow,Y}; r_empty output 1; r_drop output 1 sticky; err_seen output 1 sticky.

Function
REQ-009 SHALL implement FSM states IDLE, START, CFG, FEED, DRAIN, DONE; busy=1 in all states except IDLE.
REQ-010 IDLE: go=1 with s_count>0 SHALL latch n_cfg, clear sent/recv counters, r_drop, err_seen, and go to START; go with empty sample FIFO SHALL be ignored.
REQ-011 START: p_start=1 for exactly one cycle, then CFG.
REQ-012 CFG: p_N SHALL show latched order from CFG onward until IDLE; one cycle, then FEED.
REQ-013 FEED: p_X SHALL equal sample FIFO head combinationally; on each edge with p_ready=1 and FIFO non-empty, SHALL pop head and increment sent count.
REQ-014 FEED SHALL go to DRAIN on the edge that pops the last sample.
REQ-015 DRAIN SHALL go to DONE when recv count equals sent count, or after 16 cycles in DRAIN, whichever is first.
REQ-016 DONE: done=1 and p_rst=1 for exactly one cycle, then IDLE.
REQ-017 Result captured into result FIFO on edges with busy=1, p_valid=1 and p_ready=1; each capture increments recv count.
REQ-018 Capture with result FIFO full and r_rd=0 SHALL be discarded and set r_drop; with r_rd=1 same cycle SHALL both pop and push.
REQ-019 r_rd on empty result FIFO SHALL be ignored; r_data SHALL show head, r_empty=1 when empty.
REQ-020 s_wr SHALL be accepted only in IDLE with FIFO not full; s_full SHALL read 1 while busy or full; other writes ignored.
REQ-021 p_error=1 on any edge while busy SHALL set err_seen.
REQ-022 p_start, p_rst, done SHALL be 0 outside the states named above; p_X SHALL be 0 when sample FIFO empty.

Reset
REQ-023 rst=0 at an edge SHALL force IDLE, empty both FIFOs, clear counters, and zero every output (s_full, busy, done, p_start, p_N, p_X, p_rst, r_drop, err_seen, s_count); r_empty=1.
REQ-024 Reset mid-run SHALL abort without done and without p_rst pulse; rst dominates go, s_wr, r_rd.

Configuration
REQ-025 Macro MACLAURIN_DRV_OVF_CNT_EN defined SHALL add output ovf_count 8 bits, counting captured results with overflow=1, saturating at 255, cleared on reset and run acceptance.
REQ-026 Macro undefined SHALL omit ovf_count port and its logic; all other behaviour identical.

Verification
REQ-027 Load 20 samples, go with n_cfg=2, p_ready=1, model returns 20 results -> p_start one cycle, p_N=2 next cycle, 20 pops in order, done and p_rst pulse once, 20 entries readable in order.
REQ-028 p_ready toggling 1/0 during FEED -> pop only on ready cycles, p_X holds during ready=0, sent=20.
REQ-029 Result FIFO DEPTH=32 filled with no r_rd plus one capture -> r_drop=1, 32 entries kept; capture with concurrent r_rd at full -> no drop.
REQ-030 Model returns only 18 results with n_cfg=7 -> DONE after 16 DRAIN cycles, done=1 once.
REQ-031 rst=0 during FEED with 10 samples left -> next cycle IDLE, s_count=0, r_empty=1, no done/p_rst.
REQ-032 MACLAURIN_DRV_OVF_CNT_EN defined, 5 results with overflow=1 -> ovf_count=5; p_error pulse -> err_seen=1 until next go.
